// File: rtl/ecc_pkg.sv
// Shared types and helpers for the ECC scrubber: FSM state enum, saturating
// increment, and the DATA_WIDTH -> SECDED check-bit mapping.
package ecc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HRD,
    S_SRD,
    S_SWT,
    S_SWB
  } scrub_state_e;

  // Hamming check bits plus overall parity for the supported word widths.
  function automatic int unsigned ecc_bits(input int unsigned dw);
    return (dw == 16) ? 6 : 5;
  endfunction

  // Saturating increment of a w-bit value held in a 32-bit container.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ecc_scrub_timer.sv
// Scrub interval timer: counts enabled idle cycles and raises a pending flag
// that stays set until the scrubber finishes the access.
module ecc_scrub_timer #(
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scrub_en,
  input  logic i_clear,
  output logic o_pending
);

  localparam int TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  logic [TW-1:0] r_cnt;
  logic          r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (r_pending) begin
      if (i_clear) r_pending <= 1'b0;
    end else if (i_scrub_en) begin
      if (r_cnt == TW'(SCRUB_INTERVAL - 1)) begin
        r_cnt     <= '0;
        r_pending <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb o_pending = r_pending;

endmodule

// File: rtl/ecc_scrubber.sv
// Port controller for ecc_ram: arbitrates host requests against a background
// scrubber and counts errors. Optional dbe logging under ECC_SCRUB_LOG_EN.
module ecc_scrubber
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_DEPTH      = 256,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         host_req_valid,
  output logic                         host_req_ready,
  input  logic                         host_we,
  input  logic [$clog2(RAM_DEPTH)-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]        host_wdata,
  output logic                         host_rsp_valid,
  output logic [DATA_WIDTH-1:0]        host_rsp_data,
  output logic                         host_rsp_sbe,
  output logic                         host_rsp_dbe,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]        ram_wdata,
  output logic                         ram_write_en,
  output logic                         ram_read_en,
  input  logic [DATA_WIDTH-1:0]        ram_rdata,
  input  logic                         ram_sbe,
  input  logic                         ram_dbe,
  input  logic                         scrub_en,
  output logic                         scrub_pass_done,
  output logic [CNT_WIDTH-1:0]         sbe_count,
  output logic [CNT_WIDTH-1:0]         dbe_count
`ifdef ECC_SCRUB_LOG_EN
  ,
  output logic                         dbe_log_valid,
  output logic [$clog2(RAM_DEPTH)-1:0] dbe_log_addr
`endif
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int DW = DATA_WIDTH;

  scrub_state_e   r_state;
  logic [AW-1:0]  r_saddr;
  logic [DW-1:0]  r_fix;
  logic [CNT_WIDTH-1:0] r_sbe_cnt;
  logic [CNT_WIDTH-1:0] r_dbe_cnt;

  logic w_pending;
  logic w_idle;
  logic w_finish;
  logic w_wrap;

  ecc_scrub_timer #(
    .SCRUB_INTERVAL(SCRUB_INTERVAL)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_scrub_en(scrub_en),
    .i_clear   (w_finish),
    .o_pending (w_pending)
  );

  // A scrub finishes in SWT unless a correctable-only error needs write-back.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_finish = ((r_state == S_SWT) && !(ram_sbe && !ram_dbe)) || (r_state == S_SWB);
    w_wrap   = (r_saddr == AW'(RAM_DEPTH - 1));
  end

  always_comb begin
    host_req_ready  = 1'b0;
    host_rsp_valid  = 1'b0;
    host_rsp_data   = '0;
    host_rsp_sbe    = 1'b0;
    host_rsp_dbe    = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_write_en    = 1'b0;
    ram_read_en     = 1'b0;
    scrub_pass_done = 1'b0;
    sbe_count       = '0;
    dbe_count       = '0;
    if (!rst) begin
      host_req_ready  = w_idle;
      sbe_count       = r_sbe_cnt;
      dbe_count       = r_dbe_cnt;
      scrub_pass_done = w_finish && w_wrap;
      unique case (r_state)
        S_IDLE: begin
          if (host_req_valid) begin
            ram_addr     = host_addr;
            ram_write_en = host_we;
            ram_read_en  = !host_we;
            if (host_we) ram_wdata = host_wdata;
          end
        end
        S_HRD: begin
          host_rsp_valid = 1'b1;
          host_rsp_data  = ram_rdata;
          host_rsp_sbe   = ram_sbe;
          host_rsp_dbe   = ram_dbe;
        end
        S_SRD: begin
          ram_addr    = r_saddr;
          ram_read_en = 1'b1;
        end
        S_SWB: begin
          ram_addr     = r_saddr;
          ram_wdata    = r_fix;
          ram_write_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_saddr   <= '0;
      r_fix     <= '0;
      r_sbe_cnt <= '0;
      r_dbe_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (host_req_valid) begin
            if (!host_we) r_state <= S_HRD;
          end else if (w_pending) begin
            r_state <= S_SRD;
          end
        end
        S_HRD: begin
          r_state <= S_IDLE;
          if (ram_dbe)
            r_dbe_cnt <= CNT_WIDTH'(sat_inc(32'(r_dbe_cnt), CNT_WIDTH));
          else if (ram_sbe)
            r_sbe_cnt <= CNT_WIDTH'(sat_inc(32'(r_sbe_cnt), CNT_WIDTH));
        end
        S_SRD: r_state <= S_SWT;
        S_SWT: begin
          if (ram_dbe) begin
            r_dbe_cnt <= CNT_WIDTH'(sat_inc(32'(r_dbe_cnt), CNT_WIDTH));
          end else if (ram_sbe) begin
            r_fix     <= ram_rdata;
            r_sbe_cnt <= CNT_WIDTH'(sat_inc(32'(r_sbe_cnt), CNT_WIDTH));
            r_state   <= S_SWB;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_finish) begin
        r_state <= S_IDLE;
        r_saddr <= w_wrap ? '0 : r_saddr + 1'b1;
      end
    end
  end

`ifdef ECC_SCRUB_LOG_EN
  logic          r_log_valid;
  logic [AW-1:0] r_log_addr;
  logic [AW-1:0] r_haddr;

  // Host read address is held so an error seen in HRD can be attributed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_log_valid <= 1'b0;
      r_log_addr  <= '0;
      r_haddr     <= '0;
    end else begin
      if (w_idle && host_req_valid && !host_we) r_haddr <= host_addr;
      if ((r_state == S_HRD) && ram_dbe) begin
        r_log_valid <= 1'b1;
        r_log_addr  <= r_haddr;
      end else if ((r_state == S_SWT) && ram_dbe) begin
        r_log_valid <= 1'b1;
        r_log_addr  <= r_saddr;
      end
    end
  end

  always_comb begin
    dbe_log_valid = !rst && r_log_valid;
    dbe_log_addr  = rst ? '0 : r_log_addr;
  end
`endif

endmodule

// File: tb/tb_ecc_scrubber.sv
// Self-checking bench for ecc_scrubber with a behavioural RAM and a
// transaction-schedule reference model. Build with ECC_SCRUB_LOG_EN to cover logging.
module tb_ecc_scrubber;

  localparam int SI   = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  localparam int K_HRSP = 1, K_SRD = 2, K_SWT = 3, K_SWB = 4;

  logic       clk, rst;
  logic       host_req_valid, host_req_ready, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_rsp_valid, host_rsp_sbe, host_rsp_dbe;
  logic [7:0] host_rsp_data;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_write_en, ram_read_en, ram_sbe, ram_dbe;
  logic       scrub_en, scrub_pass_done;
  logic [CW-1:0] sbe_count, dbe_count;
`ifdef ECC_SCRUB_LOG_EN
  logic       dbe_log_valid;
  logic [7:0] dbe_log_addr;
`endif

  ecc_scrubber #(
    .DATA_WIDTH(8), .RAM_DEPTH(256), .SCRUB_INTERVAL(SI), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
    .host_rsp_sbe(host_rsp_sbe), .host_rsp_dbe(host_rsp_dbe),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ram_rdata(ram_rdata), .ram_sbe(ram_sbe), .ram_dbe(ram_dbe),
    .scrub_en(scrub_en), .scrub_pass_done(scrub_pass_done),
    .sbe_count(sbe_count), .dbe_count(dbe_count)
`ifdef ECC_SCRUB_LOG_EN
    , .dbe_log_valid(dbe_log_valid), .dbe_log_addr(dbe_log_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural RAM: err 0 clean, 1 corrected single-bit, 2 uncorrectable.
  logic [7:0] mem [256];
  logic [1:0] err [256];
  int         wr_cnt [256];
  logic [7:0] last_wr_addr, last_wr_data, last_rd_addr;
  logic       inj_req;
  logic [7:0] inj_a, inj_d;
  logic [1:0] inj_k;

  function automatic logic [7:0] ram_view(input logic [7:0] d, input logic [1:0] k);
    return (k == 2'd2) ? (d ^ 8'h03) : d;
  endfunction

  always @(posedge clk) begin
    if (ram_read_en) begin
      ram_rdata    <= ram_view(mem[ram_addr], err[ram_addr]);
      ram_sbe      <= (err[ram_addr] == 2'd1);
      ram_dbe      <= (err[ram_addr] == 2'd2);
      last_rd_addr <= ram_addr;
    end
    if (ram_write_en) begin
      mem[ram_addr]    <= ram_wdata;
      err[ram_addr]    <= 2'd0;
      wr_cnt[ram_addr] <= wr_cnt[ram_addr] + 1;
      last_wr_addr     <= ram_addr;
      last_wr_data     <= ram_wdata;
    end
    if (inj_req) begin
      mem[inj_a] <= inj_d;
      err[inj_a] <= inj_k;
    end
  end

  // Reference model: a queue of scheduled busy cycles plus interval/counter arithmetic.
  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    bit         sbe;
    bit         dbe;
  } rec_t;

  rec_t q[$];
  int   m_timer = 0, m_saddr = 0, m_sbe = 0, m_dbe = 0, m_fin_cnt = 0, dut_pd = 0;
  bit   m_pend = 0, m_swt_next = 0, m_logv = 0;
  logic [7:0] m_loga = '0;

  always @(negedge clk) begin
    rec_t r, n;
    logic [7:0] e_addr, e_wdata, e_rdata, la;
    bit e_ready, e_rd, e_wr, e_rv, e_rs, e_rdb, e_pd, fin, cs, cd, ld;
    #2;
    e_addr = '0; e_wdata = '0; e_rdata = '0; la = '0;
    e_ready = 0; e_rd = 0; e_wr = 0; e_rv = 0; e_rs = 0; e_rdb = 0; e_pd = 0;
    fin = 0; cs = 0; cd = 0; ld = 0;
    m_swt_next = 0;
    if (!rst) begin
      if (q.size() != 0) begin
        r = q.pop_front();
        case (r.kind)
          K_HRSP: begin
            e_rv = 1; e_rdata = r.data; e_rs = r.sbe; e_rdb = r.dbe;
            cd = r.dbe; cs = r.sbe && !r.dbe;
            if (r.dbe) begin ld = 1; la = r.addr; end
          end
          K_SRD: begin
            e_rd = 1; e_addr = 8'(m_saddr);
            n.kind = K_SWT; n.addr = e_addr; n.data = mem[e_addr];
            n.sbe = (err[e_addr] == 2'd1); n.dbe = (err[e_addr] == 2'd2);
            q.push_back(n);
            m_swt_next = 1;
          end
          K_SWT: begin
            if (r.dbe) begin
              cd = 1; fin = 1; ld = 1; la = r.addr;
            end else if (r.sbe) begin
              cs = 1;
              n = r; n.kind = K_SWB;
              q.push_back(n);
            end else begin
              fin = 1;
            end
          end
          default: begin
            e_wr = 1; e_addr = r.addr; e_wdata = r.data; fin = 1;
          end
        endcase
      end else begin
        e_ready = 1;
        if (host_req_valid) begin
          e_addr = host_addr;
          if (host_we) begin
            e_wr = 1; e_wdata = host_wdata;
          end else begin
            e_rd = 1;
            n.kind = K_HRSP; n.addr = host_addr;
            n.data = ram_view(mem[host_addr], err[host_addr]);
            n.sbe = (err[host_addr] == 2'd1); n.dbe = (err[host_addr] == 2'd2);
            q.push_back(n);
          end
        end else if (m_pend) begin
          n.kind = K_SRD; n.addr = '0; n.data = '0; n.sbe = 0; n.dbe = 0;
          q.push_back(n);
        end
      end
      e_pd = fin && (m_saddr == 255);
    end

    check("ready", host_req_ready, e_ready);
    check("ram_read_en", ram_read_en, e_rd);
    check("ram_write_en", ram_write_en, e_wr);
    if (rst || e_rd || e_wr) check("ram_addr", ram_addr, e_addr);
    if (rst || e_wr) check("ram_wdata", ram_wdata, e_wdata);
    check("rsp_valid", host_rsp_valid, e_rv);
    if (rst || e_rv) begin
      check("rsp_data", host_rsp_data, e_rdata);
      check("rsp_sbe", host_rsp_sbe, e_rs);
      check("rsp_dbe", host_rsp_dbe, e_rdb);
    end
    check("pass_done", scrub_pass_done, e_pd);
    check("sbe_count", sbe_count, rst ? 0 : m_sbe);
    check("dbe_count", dbe_count, rst ? 0 : m_dbe);
`ifdef ECC_SCRUB_LOG_EN
    check("log_valid", dbe_log_valid, rst ? 0 : m_logv);
    if (rst || m_logv) check("log_addr", dbe_log_addr, rst ? 8'h00 : m_loga);
`endif
    if (scrub_pass_done) dut_pd++;

    if (rst) begin
      q.delete();
      m_timer = 0; m_pend = 0; m_saddr = 0; m_sbe = 0; m_dbe = 0;
      m_logv = 0; m_loga = '0;
    end else begin
      if (cs && m_sbe < CMAX) m_sbe++;
      if (cd && m_dbe < CMAX) m_dbe++;
      if (ld) begin m_logv = 1; m_loga = la; end
      if (fin) begin
        m_fin_cnt++;
        m_saddr = (m_saddr + 1) % 256;
      end
      if (m_pend) begin
        if (fin) m_pend = 0;
      end else if (scrub_en) begin
        if (m_timer == SI - 1) begin m_pend = 1; m_timer = 0; end
        else m_timer++;
      end
    end
  end

  task automatic inject(input logic [7:0] a, input logic [7:0] d, input logic [1:0] k);
    @(negedge clk);
    inj_req = 1; inj_a = a; inj_d = d; inj_k = k;
    @(negedge clk);
    inj_req = 0;
  endtask

  task automatic host_op(input bit we, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output bit rs, output bit rdb);
    bit acc;
    acc = 0;
    @(negedge clk);
    host_req_valid = 1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      #3;
      if (host_req_ready) acc = 1;
      else @(negedge clk);
    end
    @(negedge clk);
    host_req_valid = 0; host_we = 0;
    #3;
    rd = host_rsp_data; rs = host_rsp_sbe; rdb = host_rsp_dbe;
    check("host_accept_bound", acc, 1);
    if (!we) check("rsp_next_cycle", host_rsp_valid, 1);
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #3;
      if (q.size() == 0 && !m_pend) ok = 1;
    end
    check("quiet_bound", ok, 1);
  endtask

  initial begin
    logic [7:0] rd;
    bit rs, rdb, hit;
    int rc, w0;
    logic [7:0] a6;

    rst = 1; host_req_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    scrub_en = 0; inj_req = 0; inj_a = '0; inj_d = '0; inj_k = '0;
    repeat (3) @(negedge clk);
    #3;
    check("reset_ready", host_req_ready, 0);
    check("reset_sbe", sbe_count, 0);
    @(negedge clk); rst = 0;

    // Host write then read back.
    host_op(1, 8'h10, 8'hA5, rd, rs, rdb);
    host_op(0, 8'h10, 8'h00, rd, rs, rdb);
    check("t1_data", rd, 8'hA5);
    check("t1_sbe", rs, 0);
    check("t1_dbe", rdb, 0);

    // One full scrub pass over faults at 0x03 (sbe) and 0x07 (dbe).
    inject(8'h03, 8'h3C, 2'd1);
    inject(8'h07, 8'h55, 2'd2);
    scrub_en = 1;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk); #3;
      if (m_fin_cnt >= 257) hit = 1;
    end
    check("pass_bound", hit, 1);
    @(negedge clk); scrub_en = 0;
    #3;
    check("t2_sbe_count", sbe_count, 1);
    check("t2_wb_addr", last_wr_addr, 8'h03);
    check("t2_wb_data", last_wr_data, 8'h3C);
    check("t3_dbe_count", dbe_count, 1);
    check("t3_no_wr_07", wr_cnt[7], 0);
    check("t4_pass_pulses", dut_pd, 1);
    check("t4_addr_wrap", last_rd_addr, 8'h00);
`ifdef ECC_SCRUB_LOG_EN
    check("t3_log_valid", dbe_log_valid, 1);
    check("t3_log_addr", dbe_log_addr, 8'h07);
`endif
    wait_quiet();
    host_op(0, 8'h03, 8'h00, rd, rs, rdb);
    check("t2_reread", rd, 8'h3C);
    check("t2_reread_sbe", rs, 0);

    // Continuous host traffic keeps priority over a pending scrub.
    wait_quiet();
    @(negedge clk);
    host_req_valid = 1; host_we = 1; scrub_en = 1;
    rc = 0;
    for (int i = 0; i < 40; i++) begin
      host_addr = 8'(8'h80 + i); host_wdata = 8'($urandom);
      #3;
      if (host_req_ready) rc++;
      @(negedge clk);
    end
    host_req_valid = 0; host_we = 0;
    check("t5_ready_cycles", rc, 40);
    repeat (10) @(negedge clk);
    scrub_en = 0;

    // Reset during SWT drops the pending write-back.
    wait_quiet();
    a6 = 8'(m_saddr);
    inject(a6, 8'h5A, 2'd1);
    w0 = wr_cnt[a6];
    scrub_en = 1;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (m_swt_next) begin rst = 1; hit = 1; end
    end
    check("t6_swt_bound", hit, 1);
    @(negedge clk); rst = 0; scrub_en = 0;
    #3;
    check("t6_ready", host_req_ready, 1);
    check("t6_sbe_zero", sbe_count, 0);
    check("t6_dbe_zero", dbe_count, 0);
    repeat (10) @(negedge clk);
    check("t6_no_wb", wr_cnt[a6], w0);

    // Counter saturation.
    inject(8'h50, 8'h11, 2'd1);
    inject(8'h51, 8'h22, 2'd2);
    for (int i = 0; i < CMAX + 3; i++) host_op(0, 8'h50, 8'h00, rd, rs, rdb);
    check("sat_sbe", sbe_count, 4'hF);
    host_op(0, 8'h50, 8'h00, rd, rs, rdb);
    check("sat_sbe_hold", sbe_count, 4'hF);
    for (int i = 0; i < CMAX + 3; i++) host_op(0, 8'h51, 8'h00, rd, rs, rdb);
    check("sat_dbe", dbe_count, 4'hF);

    // Randomised traffic, faults, enables and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 199) == 0);
      host_req_valid = $urandom_range(0, 1) == 1;
      host_we        = $urandom_range(0, 1) == 1;
      host_addr      = 8'($urandom);
      host_wdata     = 8'($urandom);
      scrub_en       = ($urandom_range(0, 4) != 0);
      inj_req        = ($urandom_range(0, 19) == 0);
      inj_a          = 8'($urandom);
      inj_d          = 8'($urandom);
      inj_k          = 2'($urandom_range(1, 2));
    end
    @(negedge clk);
    rst = 0; host_req_valid = 0; inj_req = 0; scrub_en = 0;
    repeat (5) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
